// File: rtl/fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// fnd_scan_driver
//
// Time-multiplexed 4-digit seven-segment (FND) driver. A binary value is
// saturated to 9999, converted to BCD by a sequential double-dabble engine
// (14 shift iterations), and committed atomically into the digit register.
// Four digits are scanned continuously at SCAN_HZ with optional leading-zero
// blanking.
//
// Handshake: update_valid is a request qualified by busy. A request is taken
// on a rising edge only while busy=0; requests while busy=1 are dropped, not
// queued. done pulses for one cycle while the new digits are being committed.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   update_valid request to load value (taken only when busy=0)
//   value[13:0]  binary value, saturated to 9999
//   dp[3:0]      decimal-point enables, bit0 = rightmost digit (live)
//   blank_lead   blank leading zeros when 1 (live)
//   busy         conversion in progress (SHIFT or COMMIT)
//   done         one-cycle pulse when digits are committed
//   fnd_com[3:0] digit enables, active-low, one-hot-low
//   fnd_data[7:0] segments, active-low: bit7=dp, bits6:0 = g..a
// -----------------------------------------------------------------------------
module fnd_scan_driver #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update_valid,
    input  logic [13:0] value,
    input  logic [3:0]  dp,
    input  logic        blank_lead,
    output logic        busy,
    output logic        done,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  iter_q;
    logic [15:0] digits_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]  idx_q;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [15:0] dabble_adj(input logic [15:0] b);
        logic [15:0] r;
        r[3:0]   = (b[3:0]   >= 4'd5) ? b[3:0]   + 4'd3 : b[3:0];
        r[7:4]   = (b[7:4]   >= 4'd5) ? b[7:4]   + 4'd3 : b[7:4];
        r[11:8]  = (b[11:8]  >= 4'd5) ? b[11:8]  + 4'd3 : b[11:8];
        r[15:12] = (b[15:12] >= 4'd5) ? b[15:12] + 4'd3 : b[15:12];
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ---------------- conversion FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // ---------------- conversion FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (update_valid) state_next = S_SHIFT;
            S_SHIFT:  if (iter_q == 4'd13) state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ---------------- conversion FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_SHIFT:  busy = 1'b1;
            S_COMMIT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- double-dabble datapath ----------------
    logic [15:0] bcd_adj;
    assign bcd_adj = dabble_adj(bcd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            digits_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (update_valid) begin
                        bin_q  <= (value > 14'd9999) ? 14'd9999 : value;
                        bcd_q  <= '0;
                        iter_q <= '0;
                    end
                end
                S_SHIFT: begin
                    // {bcd,bin} shifted left by one after adjustment
                    bcd_q  <= {bcd_adj[14:0], bin_q[13]};
                    bin_q  <= {bin_q[12:0], 1'b0};
                    iter_q <= iter_q + 4'd1;
                end
                S_COMMIT: digits_q <= bcd_q;
                default: ;
            endcase
        end
    end

    // ---------------- scan divider and digit index ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(DIV - 1)) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ---------------- digit select, blanking, registered outputs ----------------
    logic [3:0] cur_digit;
    logic       blank3, blank2, blank1, cur_blank;

    assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

    // A digit is blanked only if it and every digit above it are zero.
    assign blank3 = blank_lead && (digits_q[15:12] == 4'd0);
    assign blank2 = blank3 && (digits_q[11:8] == 4'd0);
    assign blank1 = blank2 && (digits_q[7:4] == 4'd0);

    always_comb begin
        cur_blank = 1'b0;
        case (idx_q)
            2'd1:    cur_blank = blank1;
            2'd2:    cur_blank = blank2;
            2'd3:    cur_blank = blank3;
            default: cur_blank = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else begin
            fnd_com  <= ~(4'b0001 << idx_q);
            fnd_data <= {~dp[idx_q], cur_blank ? 7'h7F : seg(cur_digit)};
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// Testbench for fnd_scan_driver with DIV=4 (CLK_HZ=8, SCAN_HZ=2).
// Inputs are driven and outputs sampled on the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_fnd_scan_driver;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update_valid = 1'b0;
    logic [13:0] value = '0;
    logic [3:0]  dp = '0;
    logic        blank_lead = 1'b0;
    logic        busy, done;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    always #5 clk = ~clk;

    fnd_scan_driver #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
        .clk(clk), .rst_n(rst_n), .update_valid(update_valid), .value(value),
        .dp(dp), .blank_lead(blank_lead), .busy(busy), .done(done),
        .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];   // expected {d3,d2,d1,d0} segment bytes per conversion
    logic [11:0] frame_q[$]; // expected {fnd_com, fnd_data} per clock

    typedef struct {
        logic [13:0] value;
        logic [3:0]  dp;
        logic        bl;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Visit each digit position and compare its segment byte.
    task automatic check_digits(input logic [31:0] e, input string nm);
        logic found;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int t = 0; t < 24; t++) begin
                if (fnd_com === ~(4'b0001 << k)) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("%s scan%0d_found", nm, k), 32'(found), 32'd1);
            chk($sformatf("%s digit%0d", nm, k), 32'(fnd_data), 32'(e[k*8 +: 8]));
        end
    endtask

    // One request; measures done latency / busy fall, then checks display.
    task automatic convert(input logic [13:0] v, input logic [3:0] d, input logic bl,
                           input logic [31:0] e, input string nm);
        int done_k, fall_k, n_done;
        dp = d;
        blank_lead = bl;
        exp_q.push_back(e);
        @(negedge clk);
        update_valid = 1'b1;
        value = v;
        @(negedge clk);
        update_valid = 1'b0;
        done_k = 0; fall_k = 0; n_done = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            if (busy === 1'b0 && fall_k == 0) fall_k = k;
            @(negedge clk);
        end
        chk({nm, " done_latency"}, 32'(done_k), 32'd15);
        chk({nm, " done_pulses"}, 32'(n_done), 32'd1);
        chk({nm, " busy_fall"}, 32'(fall_k), 32'd16);
        check_digits(exp_q.pop_front(), nm);
    endtask

    initial begin
        int d1, d2, n_done;
        logic saw_done;
        logic [3:0] prev_com;
        logic found;

        vecs[0] = '{14'd1234,  4'b0000, 1'b0, 32'hF9A4B099};
        vecs[1] = '{14'h3FFF,  4'b0000, 1'b0, 32'h90909090};
        vecs[2] = '{14'd10000, 4'b0000, 1'b0, 32'h90909090};
        vecs[3] = '{14'd7,     4'b0100, 1'b1, 32'hFF7FFFF8};
        vecs[4] = '{14'd0,     4'b0000, 1'b1, 32'hFFFFFFC0};
        vecs[5] = '{14'd1234,  4'b1010, 1'b0, 32'h79A43099};
        vecs[6] = '{14'd40,    4'b0000, 1'b1, 32'hFFFF99C0};
        vecs[7] = '{14'd1000,  4'b0000, 1'b1, 32'hF9C0C0C0};
        vecs[8] = '{14'd9999,  4'b0001, 1'b1, 32'h90909010};
        vecs[9] = '{14'd0,     4'b1111, 1'b1, 32'h7F7F7F40};

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk("reset com", 32'(fnd_com), 32'h0F);
        chk("reset data", 32'(fnd_data), 32'hFF);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset com", 32'(fnd_com), 32'h0E);
        chk("post-reset data", 32'(fnd_data), 32'hC0);

        // ---------------- table-driven conversions ----------------
        for (int i = 0; i < 10; i++)
            convert(vecs[i].value, vecs[i].dp, vecs[i].bl, vecs[i].exp, $sformatf("vec%0d", i));

        // ---------------- full frame of 1234 ----------------
        convert(14'd1234, 4'b0000, 1'b0, 32'hF9A4B099, "frame_conv");
        found = 1'b0;
        prev_com = fnd_com;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (fnd_com === 4'b1110 && prev_com === 4'b0111) begin
                found = 1'b1;
                break;
            end
            prev_com = fnd_com;
        end
        chk("frame start_found", 32'(found), 32'd1);
        for (int j = 0; j < 4; j++) frame_q.push_back({4'b1110, 8'h99});
        for (int j = 0; j < 4; j++) frame_q.push_back({4'b1101, 8'hB0});
        for (int j = 0; j < 4; j++) frame_q.push_back({4'b1011, 8'hA4});
        for (int j = 0; j < 4; j++) frame_q.push_back({4'b0111, 8'hF9});
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("frame clk%0d", j), 32'({fnd_com, fnd_data}), 32'(frame_q.pop_front()));
            @(negedge clk);
        end

        // ---------------- busy collision: request at +3 ignored ----------------
        dp = 4'b0000;
        blank_lead = 1'b0;
        exp_q.push_back(32'h9282F880);  // 5678
        @(negedge clk);
        update_valid = 1'b1; value = 14'd5678;
        @(negedge clk);
        update_valid = 1'b0;
        d1 = 0; n_done = 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 3) begin update_valid = 1'b1; value = 14'd42; end
            if (k == 4) update_valid = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (d1 == 0) d1 = k;
            end
            @(negedge clk);
        end
        chk("collision done_latency", 32'(d1), 32'd15);
        chk("collision done_pulses", 32'(n_done), 32'd1);
        check_digits(exp_q.pop_front(), "collision");

        // ---------------- request at +16 accepted ----------------
        exp_q.push_back(32'hC0C099A4);  // 42
        @(negedge clk);
        update_valid = 1'b1; value = 14'd5678;
        @(negedge clk);
        update_valid = 1'b0;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 16) begin update_valid = 1'b1; value = 14'd42; end
            if (k == 17) begin
                update_valid = 1'b0;
                chk("back2back busy", 32'(busy), 32'd1);
            end
            if (done === 1'b1) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0 && k > d1 + 1) d2 = k;
            end
            @(negedge clk);
        end
        chk("back2back done1", 32'(d1), 32'd15);
        chk("back2back done2", 32'(d2), 32'd31);
        check_digits(exp_q.pop_front(), "back2back");

        // ---------------- reset mid-conversion ----------------
        @(negedge clk);
        update_valid = 1'b1; value = 14'd9999;
        @(negedge clk);
        update_valid = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k < 7; k++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst com", 32'(fnd_com), 32'h0F);
        chk("midrst data", 32'(fnd_data), 32'hFF);
        chk("midrst busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst no_done", 32'(saw_done), 32'd0);
        exp_q.push_back(32'hC0C0C0C0);
        check_digits(exp_q.pop_front(), "midrst");
        convert(14'd805, 4'b0000, 1'b0, 32'hC080C092, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
